add_arbiter: RTL and testbench
==============================

# add_arbiter

Round-robin arbiter and sequencer that shares one `Brent_Kung_Adder` instance (WIDTH-bit operands, carry-in, WIDTH+1-bit result) among NREQ requesters. The block sits between the execution units and the adder. It accepts at most one add per cycle over per-requester valid/ready handshakes and returns each registered sum tagged with the requester index. With chaining compiled in, it also sequences multi-word additions by forwarding each carry-out into the next word and holding the grant until the chain ends.

## Interface

Parameters:
- `WIDTH`, 64, operand width; must match the adder instance's INPUTSIZE.
- `NREQ`, 4, number of requesters, 2..8.
- `IDW`, 2, width of `resp_id`; equals clog2(NREQ).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  request pending, one bit per requester.
- `req_ready`  out  NREQ  request accepted this cycle; one-hot or zero.
- `req_a`  in  NREQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
- `req_b`  in  NREQ*WIDTH  operand B, same packing as `req_a`.
- `req_cin`  in  NREQ  explicit carry-in per requester.
- `req_chain`  in  NREQ  more words follow in this chain; used only with ADD_CHAIN_EN.
- `resp_valid`  out  1  result register holds a valid sum.
- `resp_ready`  in  1  consumer takes the result.
- `resp_id`  out  IDW  index of the requester that owns the result.
- `resp_sum`  out  WIDTH+1  adder result; bit WIDTH is the carry-out.

## Operation

- Accept condition: `can_acc = !resp_valid || resp_ready`.
- Grant, normal case: the first index g, searching from `ptr` upward with wrap mod NREQ, that has `req_valid[g]=1`.
- `req_ready[g] = can_acc && grant valid`. All other `req_ready` bits are 0.
- `req_ready` is combinational from `req_valid`, `ptr`, lock state, `resp_valid` and `resp_ready`.
- On accept:
  - Drive the adder with `req_a[g]`, `req_b[g]` and the selected carry-in.
  - Register `resp_sum`, set `resp_id=g` and set `resp_valid=1`.
  - Update `ptr=(g+1) mod NREQ`.
- Carry-in selection: `req_cin[g]`, except when chaining is active (see Configuration).
- Draining: `resp_valid` clears when `resp_ready=1` and no new accept happens in the same cycle.
- Simultaneous drain and accept: the register reloads with the new result and `resp_valid` stays 1.
- Ownership: `resp_sum` and `resp_id` hold stable while `resp_valid && !resp_ready`.
- Requester obligations: a requester keeps `req_valid` and its operands stable until it sees `req_ready`. The arbiter does not check this.
- No request valid: nothing is accepted and `ptr` is unchanged.
- State machine (output stage):
  - EMPTY → FULL on accept.
  - FULL → EMPTY on drain without accept.
  - FULL → FULL on drain with accept, or when there is no drain.

## Timing

- Reset values: `resp_valid=0`, `resp_id=0`, `resp_sum=0`, `ptr=0`, `lock_v=0`, `lock_id=0`, `carry_q=0`.
- While `rst` is high, `req_ready` is all 0.
- Latency: a request accepted in cycle N produces `resp_valid=1` in cycle N+1.
- Throughput: one add per cycle when `resp_ready` is held at 1.
- Reset mid-operation: a pending result and any active chain are discarded. Nothing is accepted in the reset cycle.
- Adder path: the adder is combinational, so the path from operand select through the adder to `resp_sum` must close in one cycle.

## Configuration

- Macro: `ADD_CHAIN_EN`.

Defined:
- On accept from g with `req_chain[g]=1`:
  - Set `lock_v=1` and `lock_id=g`.
  - Set `carry_q = sum[WIDTH]`.
- While `lock_v=1`:
  - Only `lock_id` can be granted; `ptr` is ignored.
  - The carry-in is `carry_q`, not `req_cin`.
- Accept from `lock_id` with `req_chain=0`: clear `lock_v`, which ends the chain. That final word also uses `carry_q`.
- Lock with no request: `lock_v` persists while `lock_id` drops `req_valid`, and no other requester is served in the meantime.

Undefined:
- `req_chain` is ignored.
- Lock registers are absent.
- The carry-in is always `req_cin[g]`.

## Test plan

- Reset and single request:
  - Assert `rst` for 2 cycles; all outputs are 0.
  - Then `req_valid=0001`, a=5, b=7, cin=1; `req_ready=0001`.
  - Next cycle `resp_valid=1`, `resp_id=0`, `resp_sum=13`.
- Round-robin fairness:
  - Hold `req_valid=1111` with `resp_ready=1`.
  - Grant order is 0,1,2,3,0 on consecutive cycles.
  - `ptr` returns to 1 after the fifth accept.
- Backpressure:
  - `resp_ready=0` with `resp_valid=1`; `req_ready=0000`.
  - `resp_sum` and `resp_id` hold for 5 cycles.
  - Raise `resp_ready` with req 2 valid: the register reloads with req 2's result the same cycle and `resp_valid` stays 1.
- Carry-out:
  - a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0.
  - `resp_sum` = 0x1_0000_0000_0000_0000 (bit 64 set).
- Chaining (ADD_CHAIN_EN):
  - Requester 1 sends word0 a=all-ones, b=1, chain=1, then word1 a=0, b=0, chain=0, with requester 2 valid throughout.
  - Results: word0 sum low=0 with carry 1; word1 `resp_sum=1`.
  - Requester 2 is granted only after word1.
- Reset mid-chain:
  - Assert `rst` after word0 of a chain.
  - Lock is cleared; the next accept uses `req_cin` and arbitration starts from `ptr=0`.

Source files
------------

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one Brent-Kung adder among NREQ requesters.
// Define ADD_CHAIN_EN to enable multi-word carry chaining with grant lock.
module add_arbiter #(
    parameter int WIDTH = 64,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    input  logic [NREQ-1:0]       req_chain,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [WIDTH:0]        resp_sum
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]       state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   ptr_nxt;
    logic [IDW-1:0]   gnt;
    logic             gnt_v;
    logic             can_acc;
    logic             accept;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic             cin_req;
    logic             cin_sel;
    logic             chain_sel;
    logic [WIDTH:0]   sum;

`ifdef ADD_CHAIN_EN
    logic           lock_v;
    logic [IDW-1:0] lock_id;
    logic           carry_q;
`else
    logic unused_chain;
    assign unused_chain = ^{req_chain, chain_sel};
`endif

    assign resp_valid = (state == FULL);
    assign can_acc    = !resp_valid || resp_ready;
    assign accept     = !rst && can_acc && gnt_v;
    assign req_ready  = accept ? (NREQ'(1) << gnt) : '0;

    // A held chain pins the grant; otherwise scan upward from ptr with wrap.
    always_comb begin
        int idx;
        idx   = 0;
        gnt   = '0;
        gnt_v = 1'b0;
`ifdef ADD_CHAIN_EN
        if (lock_v) begin
            gnt   = lock_id;
            gnt_v = req_valid[lock_id];
        end else
`endif
        begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (int'(ptr) + k) % NREQ;
                if (!gnt_v && req_valid[idx]) begin
                    gnt_v = 1'b1;
                    gnt   = IDW'(idx);
                end
            end
        end
    end

    always_comb begin
        a_sel     = '0;
        b_sel     = '0;
        cin_req   = 1'b0;
        chain_sel = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt == IDW'(i)) begin
                a_sel     = req_a[i*WIDTH +: WIDTH];
                b_sel     = req_b[i*WIDTH +: WIDTH];
                cin_req   = req_cin[i];
                chain_sel = req_chain[i];
            end
        end
    end

`ifdef ADD_CHAIN_EN
    assign cin_sel = lock_v ? carry_q : cin_req;
`else
    assign cin_sel = cin_req;
`endif

    assign ptr_nxt = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + IDW'(1);

    Brent_Kung_Adder #(
        .INPUTSIZE(WIDTH)
    ) u_adder (
        .a  (a_sel),
        .b  (b_sel),
        .cin(cin_sel),
        .sum(sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            ptr      <= '0;
            resp_id  <= '0;
            resp_sum <= '0;
        end else begin
            if (accept) begin
                resp_sum <= sum;
                resp_id  <= gnt;
                ptr      <= ptr_nxt;
            end
            unique case (state)
                EMPTY: if (accept) state <= FULL;
                FULL:  if (resp_ready && !accept) state <= EMPTY;
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef ADD_CHAIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_v  <= 1'b0;
            lock_id <= '0;
            carry_q <= 1'b0;
        end else if (accept) begin
            lock_v <= chain_sel;
            if (chain_sel) begin
                lock_id <= gnt;
                carry_q <= sum[WIDTH];
            end
        end
    end
`endif

endmodule

module Brent_Kung_Adder #(
    parameter int INPUTSIZE = 64
) (
    input  logic [INPUTSIZE-1:0] a,
    input  logic [INPUTSIZE-1:0] b,
    input  logic                 cin,
    output logic [INPUTSIZE:0]   sum
);

    localparam int LG = (INPUTSIZE > 1) ? $clog2(INPUTSIZE) : 1;
    localparam int NP = 1 << LG;

    logic [NP-1:0]        g;
    logic [NP-1:0]        p;
    logic [NP-1:0]        p0;
    logic [INPUTSIZE-1:0] c;

    // Carry-in folds into bit 0's generate, so prefix G[i] is carry into i+1.
    always_comb begin
        g  = '0;
        p  = '0;
        c  = '0;
        for (int i = 0; i < INPUTSIZE; i++) begin
            g[i] = a[i] & b[i];
            p[i] = a[i] ^ b[i];
        end
        p0   = p;
        g[0] = g[0] | (p[0] & cin);
        for (int l = 0; l < LG; l++) begin
            for (int i = 0; i < NP; i++) begin
                if (((i + 1) % (1 << (l + 1))) == 0) begin
                    g[i] = g[i] | (p[i] & g[i - (1 << l)]);
                    p[i] = p[i] & p[i - (1 << l)];
                end
            end
        end
        for (int l = LG - 2; l >= 0; l--) begin
            for (int i = 0; i < NP; i++) begin
                if ((((i + 1) % (1 << (l + 1))) == 0) && (i + (1 << l) < NP)) begin
                    g[i + (1 << l)] = g[i + (1 << l)] | (p[i + (1 << l)] & g[i]);
                    p[i + (1 << l)] = p[i + (1 << l)] & p[i];
                end
            end
        end
        c[0] = cin;
        for (int i = 1; i < INPUTSIZE; i++) begin
            c[i] = g[i - 1];
        end
        sum = {g[INPUTSIZE-1], p0[INPUTSIZE-1:0] ^ c};
    end

endmodule

// File: tb/tb_add_arbiter.sv
// Randomized self-checking bench for add_arbiter against an arithmetic model.
// Chaining scenarios run only when ADD_CHAIN_EN is defined.
module tb_add_arbiter;

    localparam int W = 64;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_cin;
    logic [N-1:0]   req_chain;
    logic           resp_valid;
    logic           resp_ready;
    logic [1:0]     resp_id;
    logic [W:0]     resp_sum;

    int       n_tests = 0;
    int       n_fail  = 0;
    int       last_g;
    int       m_ptr, m_lock_id, m_id;
    bit       m_lock, m_carry, m_full;
    logic [W:0] m_sum;

    add_arbiter #(.WIDTH(W), .NREQ(N), .IDW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_chain (req_chain),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_id   (resp_id),
        .resp_sum  (resp_sum)
    );

    always #5 clk = ~clk;

    function automatic int exp_grant();
        if (rst) return -1;
        if (m_full && !resp_ready) return -1;
`ifdef ADD_CHAIN_EN
        if (m_lock) return req_valid[m_lock_id] ? m_lock_id : -1;
`endif
        for (int k = 0; k < N; k++) begin
            int idx = (m_ptr + k) % N;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(int g);
        return (g < 0) ? '0 : N'(1 << g);
    endfunction

    function automatic logic [W-1:0] rand64();
        if ($urandom_range(0, 3) == 0) return '1;
        return {$urandom, $urandom};
    endfunction

    task automatic set_req(int i, logic [W-1:0] a, logic [W-1:0] b,
                           logic cin, logic chain);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = cin;
        req_chain[i]    = chain;
    endtask

    // One clock edge; the model applies the spec's rules with plain arithmetic.
    task automatic tick();
        int g;
        g = exp_grant();
        last_g = g;
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_lock = 0; m_lock_id = 0; m_carry = 0;
            m_full = 0; m_id = 0; m_sum = '0;
        end else if (g >= 0) begin
            logic       c;
            logic [W:0] s;
            c = req_cin[g];
`ifdef ADD_CHAIN_EN
            if (m_lock) c = m_carry;
`endif
            s = {1'b0, req_a[g*W +: W]} + {1'b0, req_b[g*W +: W]} + (W+1)'(c);
            m_sum  = s;
            m_id   = g;
            m_full = 1;
            m_ptr  = (g + 1) % N;
`ifdef ADD_CHAIN_EN
            m_lock = req_chain[g];
            if (req_chain[g]) begin
                m_lock_id = g;
                m_carry   = s[W];
            end
`endif
        end else if (resp_ready) begin
            m_full = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        req_valid  = '1;
        resp_ready = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, rand64(), rand64(), 1'b1, 1'b1);
        repeat (2) begin
            @(negedge clk);
            n_tests++;
            if (req_ready !== '0)
                $display("FAIL reset_ready: got %b want 0000", req_ready);
            if (req_ready !== '0) n_fail++;
            tick();
            n_tests++;
            if ({resp_valid, resp_id, resp_sum} !== '0) begin
                n_fail++;
                $display("FAIL reset_out: v=%b id=%0d sum=%h want 0", resp_valid, resp_id, resp_sum);
            end
        end
        rst       = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single();
        set_req(0, 64'd5, 64'd7, 1'b1, 1'b0);
        req_valid  = 4'b0001;
        resp_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_ready: got %b want 0001", req_ready);
        end
        tick();
        n_tests++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_sum !== 65'd13) begin
            n_fail++;
            $display("FAIL single_resp: v=%b id=%0d sum=%0d want 1/0/13", resp_valid, resp_id, resp_sum);
        end
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        int ord [6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, rand64(), rand64(), 1'($urandom), 1'b0);
        req_valid  = '1;
        resp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_tests++;
            if (req_ready !== onehot(ord[k])) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, onehot(ord[k]));
            end
            tick();
            n_tests++;
            if (resp_valid !== 1'b1 || resp_id !== 2'(ord[k]) || resp_sum !== m_sum) begin
                n_fail++;
                $display("FAIL rr_resp[%0d]: id=%0d sum=%h want id=%0d sum=%h", k, resp_id, resp_sum, ord[k], m_sum);
            end
            set_req(ord[k], rand64(), rand64(), 1'($urandom), 1'b0);
        end
    endtask

    task automatic test_backpressure();
        resp_ready = 1'b0;
        req_valid  = 4'b0101;
        set_req(2, rand64(), rand64(), 1'($urandom), 1'b0);
        repeat (5) begin
            @(negedge clk);
            n_tests++;
            if (req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_ready: got %b want 0000", req_ready);
            end
            tick();
            n_tests++;
            if (resp_valid !== 1'b1 || resp_id !== 2'(m_id) || resp_sum !== m_sum) begin
                n_fail++;
                $display("FAIL bp_hold: v=%b id=%0d sum=%h want 1/%0d/%h", resp_valid, resp_id, resp_sum, m_id, m_sum);
            end
        end
        resp_ready = 1'b1;
        req_valid  = 4'b0100;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL bp_reload_ready: got %b want 0100", req_ready);
        end
        tick();
        n_tests++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_sum !== m_sum) begin
            n_fail++;
            $display("FAIL bp_reload: v=%b id=%0d sum=%h want 1/2/%h", resp_valid, resp_id, resp_sum, m_sum);
        end
        req_valid = '0;
    endtask

    task automatic test_carry_out();
        set_req(0, '1, 64'd1, 1'b0, 1'b0);
        req_valid  = 4'b0001;
        resp_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL cout_ready: got %b want 0001", req_ready);
        end
        tick();
        n_tests++;
        if (resp_sum !== 65'h1_0000_0000_0000_0000) begin
            n_fail++;
            $display("FAIL cout_sum: got %h want 1_0000000000000000", resp_sum);
        end
        req_valid = '0;
    endtask

`ifdef ADD_CHAIN_EN
    task automatic test_chain();
        do_reset();
        resp_ready = 1'b1;
        set_req(1, '1, 64'd1, 1'b0, 1'b1);
        set_req(2, 64'd9, 64'd10, 1'b0, 1'b0);
        req_valid = 4'b0110;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL chain_w0_ready: got %b want 0010", req_ready);
        end
        tick();
        n_tests++;
        if (resp_id !== 2'd1 || resp_sum !== 65'h1_0000_0000_0000_0000) begin
            n_fail++;
            $display("FAIL chain_w0: id=%0d sum=%h want 1/1_0000000000000000", resp_id, resp_sum);
        end
        req_valid = 4'b0100;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL chain_lock_idle: got %b want 0000", req_ready);
        end
        tick();
        set_req(1, 64'd0, 64'd0, 1'b0, 1'b0);
        req_valid = 4'b0110;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL chain_w1_ready: got %b want 0010", req_ready);
        end
        tick();
        n_tests++;
        if (resp_id !== 2'd1 || resp_sum !== 65'd1) begin
            n_fail++;
            $display("FAIL chain_w1: id=%0d sum=%h want 1/1", resp_id, resp_sum);
        end
        req_valid = 4'b0100;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL chain_release: got %b want 0100", req_ready);
        end
        tick();
        n_tests++;
        if (resp_id !== 2'd2 || resp_sum !== 65'd19) begin
            n_fail++;
            $display("FAIL chain_after: id=%0d sum=%0d want 2/19", resp_id, resp_sum);
        end
        req_valid = '0;
    endtask
`endif

    task automatic test_reset_mid_chain();
        do_reset();
        resp_ready = 1'b1;
        set_req(1, '1, 64'd1, 1'b0, 1'b1);
        req_valid = 4'b0010;
        @(negedge clk);
        tick();
        rst = 1'b1;
        set_req(0, 64'd3, 64'd4, 1'b0, 1'b0);
        set_req(1, 64'd0, 64'd0, 1'b0, 1'b0);
        req_valid = 4'b0011;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstchain_ready: got %b want 0000", req_ready);
        end
        tick();
        n_tests++;
        if (resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstchain_drop: resp_valid=%b want 0", resp_valid);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL rstchain_ptr: got %b want 0001", req_ready);
        end
        tick();
        n_tests++;
        if (resp_id !== 2'd0 || resp_sum !== 65'd7) begin
            n_fail++;
            $display("FAIL rstchain_r0: id=%0d sum=%0d want 0/7", resp_id, resp_sum);
        end
        @(negedge clk);
        tick();
        n_tests++;
        if (resp_id !== 2'd1 || resp_sum !== 65'd0) begin
            n_fail++;
            $display("FAIL rstchain_cin: id=%0d sum=%h want 1/0", resp_id, resp_sum);
        end
        req_valid = '0;
    endtask

    task automatic test_random();
        do_reset();
        req_valid = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || last_g == i) begin
                    req_valid[i] = ($urandom_range(0, 9) < 6);
                    set_req(i, rand64(), rand64(), 1'($urandom),
                            ($urandom_range(0, 3) == 0));
                end
            end
            resp_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            n_tests++;
            if (req_ready !== onehot(exp_grant())) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready, onehot(exp_grant()));
            end
            tick();
            n_tests++;
            if (resp_valid !== m_full || (m_full && (resp_id !== 2'(m_id) || resp_sum !== m_sum))) begin
                n_fail++;
                $display("FAIL rand_resp[%0d]: v=%b id=%0d sum=%h want %b/%0d/%h", c, resp_valid, resp_id, resp_sum, m_full, m_id, m_sum);
            end
        end
        req_valid = '0;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_cin    = '0;
        req_chain  = '0;
        resp_ready = 1'b0;
        last_g     = -1;
        m_ptr = 0; m_lock = 0; m_lock_id = 0; m_carry = 0;
        m_full = 0; m_id = 0; m_sum = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_carry_out();
`ifdef ADD_CHAIN_EN
        test_chain();
`endif
        test_reset_mid_chain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
